// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding, the NOP
// instruction word and the register-address width.
package pipe_ctrl_pkg;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    REDIRECT   = 2'd2,
    IMEM_WAIT  = 2'd3
  } state_e;
endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Hazard inputs and pipeline-control outputs of the fetch sequencer.
// The perf counter signals exist only when FETCH_HZ_PERF_EN is defined.
interface fetch_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_W
);
  logic          branch_taken_M;
  logic          mem_read_E;
  logic [AW-1:0] rd_E;
  logic [AW-1:0] rs1_D;
  logic [AW-1:0] rs2_D;
  logic          imem_ready;
  logic          pc_src;
  logic          pc_en;
  logic          ifd_en;
  logic          ifd_flush;
  logic          dex_flush;
  logic          emr_flush;
  logic          imem_timeout;
`ifdef FETCH_HZ_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
  logic [31:0]   wait_cnt_total;

  modport master (
    output branch_taken_M, mem_read_E, rd_E, rs1_D, rs2_D, imem_ready,
    input  pc_src, pc_en, ifd_en, ifd_flush, dex_flush, emr_flush, imem_timeout,
    input  stall_cnt, flush_cnt, wait_cnt_total
  );
  modport slave (
    input  branch_taken_M, mem_read_E, rd_E, rs1_D, rs2_D, imem_ready,
    output pc_src, pc_en, ifd_en, ifd_flush, dex_flush, emr_flush, imem_timeout,
    output stall_cnt, flush_cnt, wait_cnt_total
  );
`else
  modport master (
    output branch_taken_M, mem_read_E, rd_E, rs1_D, rs2_D, imem_ready,
    input  pc_src, pc_en, ifd_en, ifd_flush, dex_flush, emr_flush, imem_timeout
  );
  modport slave (
    input  branch_taken_M, mem_read_E, rd_E, rs1_D, rs2_D, imem_ready,
    output pc_src, pc_en, ifd_en, ifd_flush, dex_flush, emr_flush, imem_timeout
  );
`endif
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in E and the
// instruction in D; x0 never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          mem_read_E_i,
  input  logic [AW-1:0] rd_E_i,
  input  logic [AW-1:0] rs1_D_i,
  input  logic [AW-1:0] rs2_D_i,
  output logic          lu_o
);
  assign lu_o = mem_read_E_i && (rd_E_i != '0) &&
                ((rd_E_i == rs1_D_i) || (rd_E_i == rs2_D_i));
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/pipeline sequencer: redirect > imem wait > load-use stall, Mealy outputs.
// Optional perf counters are built when FETCH_HZ_PERF_EN is defined.
module fetch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int IMEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W    = 8
) (
  input logic                clock,
  input logic                reset,
  fetch_hazard_ctrl_if.slave bus
);
  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  init_q;
  logic                  timeout_q;
  logic                  to_set;
  logic                  lu;
  logic                  pc_src, pc_en, ifd_en, ifd_flush, dex_flush, emr_flush;

  load_use_detect #(.AW(REG_ADDR_W)) u_lu (
    .mem_read_E_i (bus.mem_read_E),
    .rd_E_i       (bus.rd_E),
    .rs1_D_i      (bus.rs1_D),
    .rs2_D_i      (bus.rs2_D),
    .lu_o         (lu)
  );

  // init_q marks the single cycle after reset, which still flushes everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      init_q     <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      init_q     <= 1'b0;
      timeout_q  <= timeout_q | to_set;
    end
  end

  always_comb begin
    pc_src     = 1'b1;
    pc_en      = 1'b1;
    ifd_en     = 1'b1;
    ifd_flush  = 1'b0;
    dex_flush  = 1'b0;
    emr_flush  = 1'b0;
    state_d    = RUN;
    wait_cnt_d = '0;
    to_set     = 1'b0;
    if (reset || init_q) begin
      pc_en     = 1'b0;
      ifd_en    = 1'b0;
      ifd_flush = 1'b1;
      dex_flush = 1'b1;
      emr_flush = 1'b1;
    end else if (bus.branch_taken_M) begin
      pc_src    = 1'b0;
      ifd_flush = 1'b1;
      dex_flush = 1'b1;
      emr_flush = 1'b1;
      state_d   = REDIRECT;
    end else if (!bus.imem_ready) begin
      pc_en      = 1'b0;
      ifd_flush  = 1'b1;
      state_d    = IMEM_WAIT;
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
      to_set     = (wait_cnt_d >= WAIT_CNT_W'(IMEM_WAIT_MAX));
    end else if (lu && (state_q == RUN || state_q == REDIRECT)) begin
      // the cycle after a stall the load sits in M and D is served by forwarding
      pc_en     = 1'b0;
      ifd_en    = 1'b0;
      dex_flush = 1'b1;
      state_d   = LOAD_STALL;
    end
  end

  assign bus.pc_src       = pc_src;
  assign bus.pc_en        = pc_en;
  assign bus.ifd_en       = ifd_en;
  assign bus.ifd_flush    = ifd_flush;
  assign bus.dex_flush    = dex_flush;
  assign bus.emr_flush    = emr_flush;
  assign bus.imem_timeout = !reset && (timeout_q || to_set);

`ifdef FETCH_HZ_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_tot_q;

  // state_d names exactly the event taken this cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_tot_q  <= '0;
    end else begin
      if (state_d == LOAD_STALL) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_d == REDIRECT)   flush_cnt_q <= flush_cnt_q + 32'd1;
      if (state_d == IMEM_WAIT)  wait_tot_q  <= wait_tot_q + 32'd1;
    end
  end

  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;
  assign bus.wait_cnt_total = wait_tot_q;
`endif
endmodule
